// File: rtl/frame_egress_requester.sv
// -----------------------------------------------------------------------------
// frame_egress_requester
//
// Purpose: pops frame descriptors {end_ptr, dest} from a sideband FIFO and
// streams the words between start_ptr and end_ptr out of a FWFT frame buffer
// as one AXI-Stream packet toward a switch. A stalled beat that reaches the
// timeout limit either replays the frame from start_ptr or drops it.
//
// Optional feature (macro REQ_RETRY_EN):
//   defined   - a timeout replays the frame up to MAX_RETRIES times, then drops
//   undefined - every timeout drops the frame (MAX_RETRIES is ignored)
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   scan_payload      ingress is currently receiving a payload
//   sideband_rdata    {end_ptr, dest}, valid the cycle after sideband_ren
//   sideband_empty    sideband FIFO empty
//   sideband_ren      single-cycle sideband pop
//   frame_rdata       FWFT word at frame_rptr
//   frame_rptr        frame buffer read pointer (with wrap bit)
//   frame_ren         advance frame_rptr by one
//   frame_rrst        pulse: frame_rptr loads frame_rst_rptr on the next edge
//   frame_rst_rptr    rewind target (start of the current frame)
//   m_t*              AXI-Stream master; m_tready is the only input
//   timeout           single-cycle pulse on each timeout event
//   drop_count        saturating count of dropped frames
//   dbg_state         current FSM state (debug visibility)
//
// Handshake: a beat transfers on a rising edge where m_tvalid & m_tready.
// m_tvalid is high exactly in REQ and STREAM and, once raised, m_tdata and
// m_tdest hold until the beat transfers or a timeout withdraws the frame.
// -----------------------------------------------------------------------------
module frame_egress_requester #(
  parameter int DATA_W      = 16,
  parameter int DEST_W      = 2,
  parameter int ADDR_W      = 11,
  parameter int TO_W        = 3,
  parameter int MAX_RETRIES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_payload,
  input  logic [ADDR_W+DEST_W:0]   sideband_rdata,
  input  logic                     sideband_empty,
  output logic                     sideband_ren,
  input  logic [DATA_W-1:0]        frame_rdata,
  input  logic [ADDR_W:0]          frame_rptr,
  output logic                     frame_ren,
  output logic                     frame_rrst,
  output logic [ADDR_W:0]          frame_rst_rptr,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [DEST_W-1:0]        m_tdest,
  output logic                     m_tlast,
  output logic                     timeout,
  output logic [15:0]              drop_count,
  output logic [2:0]               dbg_state
);

  localparam int PTR_W   = ADDR_W + 1;
  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_REWIND  = 3'd2,
    S_WAIT    = 3'd3,
    S_REQ     = 3'd4,
    S_STREAM  = 3'd5
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    start_q;
  logic [PTR_W-1:0]    end_q;
  logic [DEST_W-1:0]   dest_q;
  logic [TO_W-1:0]     to_q;
  logic [15:0]         drop_q;

  logic [PTR_W-1:0]    sb_end;
  logic [DEST_W-1:0]   sb_dest;
  logic [PTR_W-1:0]    next_rptr;
  logic                handshake;
  logic                timeout_fire;
  logic                retry_ok;

  assign sb_end  = sideband_rdata[ADDR_W+DEST_W:DEST_W];
  assign sb_dest = sideband_rdata[DEST_W-1:0];

  // Modulo-2^PTR_W compare, so frames that wrap the buffer end correctly.
  assign next_rptr = frame_rptr + PTR_W'(1);

  assign m_tvalid     = (state_q == S_REQ) || (state_q == S_STREAM);
  assign m_tdata      = frame_rdata;
  assign m_tdest      = dest_q;
  assign m_tlast      = m_tvalid && (next_rptr == end_q);
  assign handshake    = m_tvalid && m_tready;
  assign frame_ren    = handshake && !m_tlast;
  assign timeout_fire = m_tvalid && !m_tready && (&to_q);
  assign timeout      = timeout_fire;
  assign sideband_ren = (state_q == S_IDLE) && !sideband_empty;
  assign frame_rrst   = (state_q == S_REWIND);
  assign frame_rst_rptr = start_q;
  assign drop_count   = drop_q;
  assign dbg_state    = state_q;

`ifdef REQ_RETRY_EN
  logic [RETRY_W-1:0] retry_q;
  assign retry_ok = (retry_q < RETRY_W'(MAX_RETRIES));
`else
  logic unused_max_retries;
  assign unused_max_retries = (MAX_RETRIES > 7);
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      dest_q  <= '0;
      to_q    <= '0;
      drop_q  <= '0;
`ifdef REQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          to_q <= '0;
          if (!sideband_empty) state_q <= S_LOAD;
        end
        S_LOAD: begin
          end_q  <= sb_end;
          dest_q <= sb_dest;
          // A zero-length descriptor is consumed silently.
          state_q <= (sb_end == start_q) ? S_IDLE : S_REWIND;
        end
        S_REWIND: state_q <= S_WAIT;
        S_WAIT: begin
          if (scan_payload || !sideband_empty) state_q <= S_REQ;
        end
        S_REQ, S_STREAM: begin
          if (handshake) begin
            to_q <= '0;
            if (m_tlast) begin
              start_q <= end_q;
              state_q <= S_IDLE;
`ifdef REQ_RETRY_EN
              retry_q <= '0;
`endif
            end else begin
              state_q <= S_STREAM;
            end
          end else if (timeout_fire) begin
            // Restart the stall timer so a replay gets a full window.
            to_q <= '0;
            if (retry_ok) begin
`ifdef REQ_RETRY_EN
              retry_q <= retry_q + RETRY_W'(1);
`endif
              state_q <= S_REWIND;
            end else begin
              start_q <= end_q;
              state_q <= S_IDLE;
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
`ifdef REQ_RETRY_EN
              retry_q <= '0;
`endif
            end
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_egress_requester.sv
// Directed testbench for frame_egress_requester (default parameters).
module tb_frame_egress_requester;

`ifdef REQ_RETRY_EN
  localparam int TO_PER_DROP = 3;
  localparam int DROPS_BEFORE_WRAP = 1;
`else
  localparam int TO_PER_DROP = 1;
  localparam int DROPS_BEFORE_WRAP = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_payload = 1'b1;
  logic [13:0] sideband_rdata = '0;
  logic        sideband_empty = 1'b1;
  logic        sideband_ren;
  logic [15:0] frame_rdata;
  logic [11:0] frame_rptr = '0;
  logic        frame_ren;
  logic        frame_rrst;
  logic [11:0] frame_rst_rptr;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata;
  logic [1:0]  m_tdest;
  logic        m_tlast;
  logic        timeout;
  logic [15:0] drop_count;
  logic [2:0]  dbg_state;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [15:0] exp_q[$];

  frame_egress_requester dut (
    .clk(clk), .reset(reset), .scan_payload(scan_payload),
    .sideband_rdata(sideband_rdata), .sideband_empty(sideband_empty),
    .sideband_ren(sideband_ren), .frame_rdata(frame_rdata),
    .frame_rptr(frame_rptr), .frame_ren(frame_ren), .frame_rrst(frame_rrst),
    .frame_rst_rptr(frame_rst_rptr), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tlast(m_tlast),
    .timeout(timeout), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- frame buffer model ----------------
  // Each word encodes its own address, so expected data is {4'hA, addr}.
  assign frame_rdata = {4'hA, frame_rptr};
  always @(posedge clk) begin
    if (frame_rrst) frame_rptr <= frame_rst_rptr;
    else if (frame_ren) frame_rptr <= frame_rptr + 12'd1;
  end

  // ---------------- monitor (negedge, away from the active edge) ----------------
  int beat_cnt = 0, tlast_cnt = 0, ren_cnt = 0, rrst_cnt = 0;
  int to_cnt = 0, sbren_cnt = 0, valid_cnt = 0;
  logic [11:0] last_rptr = '0;
  logic [15:0] cap_data [0:255];
  logic [1:0]  cap_dest [0:255];
  logic        cap_last [0:255];

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      cap_data[beat_cnt[7:0]] <= m_tdata;
      cap_dest[beat_cnt[7:0]] <= m_tdest;
      cap_last[beat_cnt[7:0]] <= m_tlast;
      beat_cnt <= beat_cnt + 1;
      if (m_tlast) begin
        tlast_cnt <= tlast_cnt + 1;
        last_rptr <= frame_rptr;
      end
    end
    if (frame_ren)    ren_cnt   <= ren_cnt + 1;
    if (frame_rrst)   rrst_cnt  <= rrst_cnt + 1;
    if (timeout)      to_cnt    <= to_cnt + 1;
    if (sideband_ren) sbren_cnt <= sbren_cnt + 1;
    if (m_tvalid)     valid_cnt <= valid_cnt + 1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-deep sideband FIFO: the DUT pops it on the next edge while idle.
  task automatic push_entry(input logic [11:0] end_ptr, input logic [1:0] dest);
    sideband_rdata = {end_ptr, dest};
    sideband_empty = 1'b0;
    step();
    sideband_empty = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (dbg_state != 3'd0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, dbg_state, 3'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!m_tvalid && n < budget) begin
      step();
      n++;
    end
    chk(tag, m_tvalid, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int b0, input int start,
                             input int n, input logic [1:0] dest);
    logic [15:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back({4'hA, 12'(start + i)});
    chk({tag, ".beats"}, beat_cnt - b0, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s.data%0d", tag, i), cap_data[8'(b0 + i)], e);
      chk($sformatf("%s.dest%0d", tag, i), cap_dest[8'(b0 + i)], dest);
      chk($sformatf("%s.last%0d", tag, i), cap_last[8'(b0 + i)], (i == n - 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0, r0, t0, tl0, v0, s0, rr0;

    // Reset state
    repeat (3) step();
    chk("rst.tvalid", m_tvalid, 0);
    chk("rst.tlast", m_tlast, 0);
    chk("rst.tdest", m_tdest, 0);
    chk("rst.ren", frame_ren, 0);
    chk("rst.rrst", frame_rrst, 0);
    chk("rst.rst_rptr", frame_rst_rptr, 0);
    chk("rst.sb_ren", sideband_ren, 0);
    chk("rst.timeout", timeout, 0);
    chk("rst.drop", drop_count, 0);
    chk("rst.state", dbg_state, 0);
    reset = 1'b0;
    step();

    // Basic 4-beat frame, start 0, end 4, dest 2
    b0 = beat_cnt; r0 = ren_cnt; tl0 = tlast_cnt; rr0 = rrst_cnt; s0 = sbren_cnt;
    push_entry(12'd4, 2'd2);
    wait_idle("f1.idle", 50);
    step();
    check_frame("f1", b0, 0, 4, 2'd2);
    chk("f1.ren_pulses", ren_cnt - r0, 3);
    chk("f1.tlast_cnt", tlast_cnt - tl0, 1);
    chk("f1.rrst_pulses", rrst_cnt - rr0, 1);
    chk("f1.sb_pops", sbren_cnt - s0, 1);

    // Stall 8 cycles in REQ: timeout on the 8th stalled cycle
    m_tready = 1'b0;
    b0 = beat_cnt;
    push_entry(12'd6, 2'd1);
    wait_valid("to.valid", 20);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to.pulse_c%0d", k), timeout, (k == 8));
      step();
    end
    chk("to.valid_drop", m_tvalid, 0);
`ifdef REQ_RETRY_EN
    chk("to.rrst", frame_rrst, 1);
    chk("to.rewind_target", frame_rst_rptr, 4);
    m_tready = 1'b1;
    wait_idle("to.replay_idle", 50);
    step();
    check_frame("replay", b0, 4, 2, 2'd1);
    chk("to.drop", drop_count, 0);
`else
    chk("to.drop", drop_count, 1);
    chk("to.state", dbg_state, 0);
    m_tready = 1'b1;
    chk("to.no_beats", beat_cnt - b0, 0);
`endif
    step();

    // Stuck-low frame 6..9: retries exhausted (or immediate drop), then drop
    m_tready = 1'b0;
    t0 = to_cnt;
    push_entry(12'd9, 2'd3);
    wait_idle("stuck.idle", 150);
    step();
    chk("stuck.timeouts", to_cnt - t0, TO_PER_DROP);
    chk("stuck.drop", drop_count, DROPS_BEFORE_WRAP);
    chk("stuck.new_start", frame_rst_rptr, 9);
    m_tready = 1'b1;

    // One-word frame from the old end_ptr: tlast in REQ, no frame_ren
    b0 = beat_cnt; r0 = ren_cnt;
    push_entry(12'd10, 2'd0);
    wait_idle("one.idle", 50);
    step();
    check_frame("one", b0, 9, 1, 2'd0);
    chk("one.ren", ren_cnt - r0, 0);

    // Drop a frame ending at 4094 to place start_ptr there, then wrap
    m_tready = 1'b0;
    push_entry(12'd4094, 2'd1);
    wait_idle("pre_wrap.idle", 150);
    m_tready = 1'b1;
    step();
    chk("pre_wrap.drop", drop_count, DROPS_BEFORE_WRAP + 1);
    b0 = beat_cnt;
    push_entry(12'd2, 2'd1);
    wait_idle("wrap.idle", 50);
    step();
    check_frame("wrap", b0, 4094, 4, 2'd1);
    chk("wrap.tlast_rptr", last_rptr, 1);

    // Zero-length entry (end == start == 2)
    v0 = valid_cnt; s0 = sbren_cnt;
    push_entry(12'd2, 2'd3);
    repeat (6) step();
    chk("zero.no_valid", valid_cnt - v0, 0);
    chk("zero.state", dbg_state, 0);
    chk("zero.drop", drop_count, DROPS_BEFORE_WRAP + 1);
    chk("zero.sb_pop", sbren_cnt - s0, 1);

    // Hold in WAIT_PAYLOAD, then reset during STREAM beat 2
    scan_payload = 1'b0;
    tl0 = tlast_cnt;
    push_entry(12'd8, 2'd1);
    repeat (4) step();
    chk("wait.state", dbg_state, 3);
    chk("wait.no_valid", m_tvalid, 0);
    scan_payload = 1'b1;
    wait_valid("mid.valid", 10);
    chk("mid.beat1", m_tdata, 16'hA002);
    step();
    chk("mid.state_stream", dbg_state, 5);
    chk("mid.beat2", m_tdata, 16'hA003);
    reset = 1'b1;
    step();
    chk("mid.tvalid", m_tvalid, 0);
    chk("mid.tlast", m_tlast, 0);
    chk("mid.tdest", m_tdest, 0);
    chk("mid.ren", frame_ren, 0);
    chk("mid.rrst", frame_rrst, 0);
    chk("mid.rst_rptr", frame_rst_rptr, 0);
    chk("mid.state", dbg_state, 0);
    chk("mid.drop", drop_count, 0);
    reset = 1'b0;
    step();
    chk("mid.no_tlast", tlast_cnt - tl0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_egress_requester.md
FRAME_EGRESS_REQUESTER -- requirements
Module: frame_egress_requester

Interface
REQ-001 Parameter: DATA_W, 16, egress data width in bits.
REQ-002 Parameter: DEST_W, 2, egress destination width in bits.
REQ-003 Parameter: ADDR_W, 11, frame buffer address width; all pointers are ADDR_W+1 bits, including the wrap bit.
REQ-004 Parameter: TO_W, 3, timeout counter width.
REQ-005 Parameter: MAX_RETRIES, 2, retry attempts after the first timeout of a frame (range 0..7).
REQ-006 Port: clk  in  1  clock; all logic SHALL be on rising edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: scan_payload  in  1  ingress is currently receiving a payload.
REQ-009 Port: sideband_rdata  in  ADDR_W+1+DEST_W  {end_ptr, dest}; valid one cycle after sideband_ren.
REQ-010 Port: sideband_empty  in  1  sideband FIFO empty.
REQ-011 Port: sideband_ren  out  1  single-cycle sideband pop.
REQ-012 Port: frame_rdata  in  DATA_W  FWFT word at frame_rptr.
REQ-013 Port: frame_rptr  in  ADDR_W+1  current frame buffer read pointer.
REQ-014 Port: frame_ren  out  1  advance frame_rptr by one.
REQ-015 Port: frame_rrst  out  1  single-cycle pulse; frame_rptr loads frame_rst_rptr on the next edge.
REQ-016 Port: frame_rst_rptr  out  ADDR_W+1  rewind target, equal to start_ptr.
REQ-017 Port: m_tvalid, m_tready, m_tdata[DATA_W], m_tdest[DEST_W], m_tlast  AXIS master to switch; m_tready is the only input.
REQ-018 Port: timeout  out  1  single-cycle pulse on each timeout event.
REQ-019 Port: drop_count  out  16  saturating count of dropped frames.

Function
REQ-020 States: IDLE, LOAD, REWIND, WAIT_PAYLOAD, REQ, STREAM.
- IDLE -> LOAD when ~sideband_empty; sideband_ren pulses for one cycle.
REQ-021 LOAD: latch end_ptr and dest.
- end_ptr == start_ptr (zero length): return to IDLE, no AXIS activity, no drop count.
- Otherwise -> REWIND.
REQ-022 REWIND: frame_rrst pulses for one cycle -> WAIT_PAYLOAD.
REQ-023 WAIT_PAYLOAD -> REQ when scan_payload | ~sideband_empty, evaluated in the cycle after frame_rrst.
REQ-024 m_tvalid SHALL be high exactly in REQ and STREAM. m_tdata = frame_rdata. m_tdest = latched dest, stable for the whole frame.
REQ-025 Beat handshake = m_tvalid & m_tready; frame_ren = handshake & ~m_tlast.
- REQ -> STREAM on the first handshake.
REQ-026 m_tlast SHALL be high when frame_rptr+1 == end_ptr (modulo 2^(ADDR_W+1)); a one-word frame asserts tlast in REQ.
REQ-027 Handshake with m_tlast: start_ptr <= end_ptr, retry count cleared, -> IDLE.
REQ-028 Timeout counter (TO_W bits):
- increments each cycle of m_tvalid & ~m_tready;
- clears on handshake and in IDLE.
REQ-029 Timeout fires when the counter is all-ones and m_tready is low.
- timeout pulses, and m_tvalid drops the next cycle.
- Retry handling per REQ-035/036.
REQ-030 m_tdata SHALL be stable while m_tvalid & ~m_tready.
REQ-031 Pointer arithmetic wraps at 2^(ADDR_W+1); an end_ptr below start_ptr is legal.
REQ-032 drop_count holds at 16'hFFFF.

Reset
REQ-033 Synchronous reset SHALL force:
- state IDLE; start_ptr, dest, counters and drop_count to 0;
- all outputs low/zero, frame_rst_rptr 0.
REQ-034 Reset mid-frame SHALL abandon the frame without a tlast beat and without counting a drop.

Configuration
REQ-035 With REQ_RETRY_EN defined:
- a timeout with retry count < MAX_RETRIES increments the retry count and goes to REWIND, replaying the frame from start_ptr;
- otherwise the frame is dropped (REQ-036).
REQ-036 Without REQ_RETRY_EN, MAX_RETRIES is ignored and every timeout drops the frame. A drop sets start_ptr <= end_ptr, increments drop_count, and returns to IDLE.

Verification
REQ-037 Sideband {end=4, dest=2}, start 0, m_tready=1 -> 4 beats, m_tdest=2, tlast on beat 4 only, frame_ren 3 pulses.
REQ-038 m_tready=0 for 8 cycles in REQ, TO_W=3 -> timeout pulse at cycle 8, m_tvalid low next cycle.
- With REQ_RETRY_EN: frame_rrst, then replay.
- Without REQ_RETRY_EN: drop_count=1.
REQ-039 REQ_RETRY_EN, MAX_RETRIES=2, m_tready stuck low -> 3 timeouts, drop_count=1, next frame starts at the old end_ptr.
REQ-040 start=4094, end=2 with ADDR_W=11 (wrap) -> 4 beats, tlast at rptr=1.
REQ-041 Zero-length entry (end=start) -> no m_tvalid, back to IDLE, drop_count unchanged.
REQ-042 Reset asserted during STREAM beat 2 -> all outputs 0 next cycle, state IDLE, drop_count 0.
